count_sequencer: RTL and testbench

- Command-driven controller that sequences a free-running-style counter datapath.
- Accepts a job over a valid/ready handshake. A job is a terminal count plus a repeat count.
- Runs the counter through the programmed number of periods and emits a one-cycle tick per wrap and a done pulse at job end.
- Sits between a host/control FSM and the count/LED datapath. Supports pause and abort.

---
 rtl/count_seq_pkg.sv | 19 +
 rtl/count_sequencer_core.sv | 28 ++
 rtl/count_sequencer.sv | 99 +++++++++
 tb/tb_count_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_seq_pkg.sv
// Shared types and default widths for the count sequencer controller and its counter datapath.
package count_seq_pkg;

    localparam int unsigned CNT_WIDTH_DEF = 4;
    localparam int unsigned REP_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // RUN and PAUSE both own a live job that abort can cancel.
    function automatic logic is_active(input state_t s);
        return (s == ST_RUN) || (s == ST_PAUSE);
    endfunction

endpackage

// File: rtl/count_sequencer_core.sv
// Counter datapath: counts 0..i_tc while enabled, wraps to 0, flags the wrap combinationally.
module count_core
    import count_seq_pkg::*;
#(
    parameter int unsigned P_CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clr,
    input  logic                   i_en,
    input  logic [P_CNT_WIDTH-1:0] i_tc,
    output logic [P_CNT_WIDTH-1:0] o_cnt,
    output logic                   o_wrap
);

    assign o_wrap = i_en & (o_cnt == i_tc);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_cnt <= '0;
        end else if (i_clr) begin
            o_cnt <= '0;
        end else if (i_en) begin
            o_cnt <= o_wrap ? '0 : o_cnt + P_CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// Job controller: accepts (tc, rep) jobs, sequences count_core through rep periods with pause/abort.
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int unsigned P_CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int unsigned P_REP_WIDTH = REP_WIDTH_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic [P_CNT_WIDTH-1:0] i_cmd_tc,
    input  logic [P_REP_WIDTH-1:0] i_cmd_rep,
    input  logic                   i_pause,
    input  logic                   i_abort,
    output logic [P_CNT_WIDTH-1:0] o_cnt,
    output logic                   o_tick,
    output logic [P_REP_WIDTH-1:0] o_rep_cnt,
    output logic                   o_busy,
    output logic                   o_done
);

    state_t                 state;
    state_t                 state_nxt;
    logic [P_CNT_WIDTH-1:0] tc_q;
    logic [P_REP_WIDTH-1:0] rep_q;
    logic [P_REP_WIDTH-1:0] rep_inc;
    logic                   accept;
    logic                   core_en;
    logic                   core_clr;
    logic                   wrap;
    logic                   last_wrap;

    assign accept    = (state == ST_IDLE) & i_cmd_valid & o_cmd_ready;
    // Counting continues on the edge where pause drops, even while still in PAUSE,
    // so a pause of N sampled edges delays the job by exactly N cycles.
    assign core_en   = is_active(state) & ~i_abort & ~i_pause;
    assign core_clr  = ~is_active(state) | i_abort;
    assign rep_inc   = o_rep_cnt + P_REP_WIDTH'(1);
    assign last_wrap = wrap & (rep_q != '0) & (rep_inc == rep_q);

    count_core #(
        .P_CNT_WIDTH(P_CNT_WIDTH)
    ) u_core (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_clr  (core_clr),
        .i_en   (core_en),
        .i_tc   (tc_q),
        .o_cnt  (o_cnt),
        .o_wrap (wrap)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_RUN;
            end
            ST_RUN, ST_PAUSE: begin
                if (i_abort)        state_nxt = ST_IDLE;
                else if (last_wrap) state_nxt = ST_DONE;
                else if (i_pause)   state_nxt = ST_PAUSE;
                else                state_nxt = ST_RUN;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            tc_q        <= '0;
            rep_q       <= '0;
            o_cmd_ready <= 1'b0;
            o_busy      <= 1'b0;
            o_tick      <= 1'b0;
            o_done      <= 1'b0;
            o_rep_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            o_cmd_ready <= (state_nxt == ST_IDLE);
            o_busy      <= (state_nxt != ST_IDLE);
            o_tick      <= wrap;
            o_done      <= last_wrap;
            if (accept) begin
                tc_q      <= i_cmd_tc;
                rep_q     <= i_cmd_rep;
                o_rep_cnt <= '0;
            end else if (wrap) begin
                o_rep_cnt <= rep_inc;
            end
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer: directed scenarios plus random stimulus vs a reference model.
module tb_count_sequencer;

    localparam int unsigned CW = 4;
    localparam int unsigned RW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [CW-1:0] cmd_tc;
    logic [RW-1:0] cmd_rep;
    logic          pause;
    logic          abort;
    logic [CW-1:0] cnt;
    logic          tick;
    logic [RW-1:0] rep_cnt;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    count_sequencer #(
        .P_CNT_WIDTH(CW),
        .P_REP_WIDTH(RW)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_cmd_valid(cmd_valid),
        .o_cmd_ready(cmd_ready),
        .i_cmd_tc   (cmd_tc),
        .i_cmd_rep  (cmd_rep),
        .i_pause    (pause),
        .i_abort    (abort),
        .o_cnt      (cnt),
        .o_tick     (tick),
        .o_rep_cnt  (rep_cnt),
        .o_busy     (busy),
        .o_done     (done)
    );

    // Reference model: a job is "active" while counting, then spends one cycle finishing.
    int m_active = 0, m_finishing = 0;
    int m_ready = 0, m_busy = 0, m_tick = 0, m_done = 0;
    int m_cnt = 0, m_tc = 0, m_rep = 0, m_rep_cnt = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active = 0; m_finishing = 0; m_ready = 0; m_busy = 0;
            m_tick = 0; m_done = 0; m_cnt = 0; m_rep_cnt = 0; m_tc = 0; m_rep = 0;
        end else if (m_finishing != 0) begin
            m_finishing = 0; m_tick = 0; m_done = 0;
            m_busy = 0; m_ready = 1; m_cnt = 0;
        end else if (m_active != 0) begin
            m_tick = 0; m_done = 0;
            if (abort) begin
                m_active = 0; m_cnt = 0; m_busy = 0; m_ready = 1;
            end else if (!pause) begin
                if (m_cnt == m_tc) begin
                    m_cnt = 0;
                    m_rep_cnt = (m_rep_cnt + 1) % (1 << RW);
                    m_tick = 1;
                    if (m_rep != 0 && m_rep_cnt == m_rep) begin
                        m_done = 1; m_finishing = 1; m_active = 0;
                    end
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end else begin
            m_tick = 0; m_done = 0; m_cnt = 0;
            if (m_ready != 0 && cmd_valid) begin
                m_tc = int'(cmd_tc); m_rep = int'(cmd_rep); m_rep_cnt = 0;
                m_active = 1; m_busy = 1; m_ready = 0;
            end else begin
                m_ready = 1; m_busy = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock and compare every output against the model away from the edge.
    task automatic cyc();
        @(negedge clk);
        check("m_ready",   32'(cmd_ready), 32'(m_ready));
        check("m_busy",    32'(busy),      32'(m_busy));
        check("m_tick",    32'(tick),      32'(m_tick));
        check("m_done",    32'(done),      32'(m_done));
        check("m_cnt",     32'(cnt),       32'(m_cnt));
        check("m_rep_cnt", 32'(rep_cnt),   32'(m_rep_cnt));
    endtask

    task automatic accept_job(input int tc, input int rep);
        cmd_valid = 1'b1;
        cmd_tc    = CW'(tc);
        cmd_rep   = RW'(rep);
        cyc();
        cmd_valid = 1'b0;
        check("accept_busy", 32'(busy), 1);
    endtask

    task automatic wait_cnt(input int val, input int limit);
        int found = 0;
        for (int i = 0; i < limit; i++) begin
            if (int'(cnt) == val) begin
                found = 1;
                break;
            end
            cyc();
        end
        check("wait_cnt", found, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks;
        int dones;
        int found;
        int exp_cnt[9];
        exp_cnt = '{0, 1, 2, 3, 0, 1, 2, 3, 0};

        rst_n = 1'b0; cmd_valid = 1'b1; cmd_tc = 4'd3; cmd_rep = 8'd2;
        pause = 1'b0; abort = 1'b0;

        // Reset held with valid high: nothing accepted, everything cleared.
        repeat (3) begin
            cyc();
            check("rst_ready", 32'(cmd_ready), 0);
            check("rst_busy",  32'(busy),      0);
            check("rst_cnt",   32'(cnt),       0);
        end
        rst_n = 1'b1; cmd_valid = 1'b0;
        cyc();
        check("ready_after_rst", 32'(cmd_ready), 1);
        check("idle_busy",       32'(busy),      0);

        // tc=3, rep=2 timeline T1..T10.
        accept_job(3, 2);
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) cyc();
            check("seq_cnt",  32'(cnt),  32'(exp_cnt[k-1]));
            check("seq_tick", 32'(tick), 32'((k == 5) || (k == 9)));
            check("seq_done", 32'(done), 32'(k == 9));
            if (k == 5) check("seq_rep1", 32'(rep_cnt), 1);
            if (k == 9) check("seq_rep2", 32'(rep_cnt), 2);
        end
        cyc();
        check("seq_ready_after", 32'(cmd_ready), 1);
        check("seq_busy_after",  32'(busy),      0);

        // Pause for 3 edges starting where cnt==2 delays completion by 3 cycles.
        accept_job(3, 1);
        cyc(); cyc();
        check("pz_cnt2", 32'(cnt), 2);
        pause = 1'b1;
        repeat (3) begin
            cyc();
            check("pz_hold", 32'(cnt),  2);
            check("pz_busy", 32'(busy), 1);
            check("pz_tick", 32'(tick), 0);
        end
        pause = 1'b0;
        cyc();
        check("pz_resume", 32'(cnt),  3);
        check("pz_nodone", 32'(done), 0);
        cyc();
        check("pz_done", 32'(done), 1);
        check("pz_tick_end", 32'(tick), 1);
        cyc();
        check("pz_ready", 32'(cmd_ready), 1);

        // Endless job: 10 periods, then abort coinciding with cnt==tc.
        accept_job(5, 0);
        ticks = 0; dones = 0;
        repeat (60) begin
            cyc();
            ticks += int'(tick);
            dones += int'(done);
        end
        check("inf_ticks",   ticks,          10);
        check("inf_nodone",  dones,          0);
        check("inf_rep_cnt", 32'(rep_cnt),   10);
        check("inf_cnt0",    32'(cnt),       0);
        wait_cnt(5, 12);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("ab_tick",  32'(tick),      0);
        check("ab_cnt",   32'(cnt),       0);
        check("ab_busy",  32'(busy),      0);
        check("ab_ready", 32'(cmd_ready), 1);
        check("ab_done",  32'(done),      0);

        // tc=0 rep=4 with a second request held valid throughout.
        cmd_valid = 1'b1; cmd_tc = 4'd0; cmd_rep = 8'd4;
        cyc();
        check("z_busy", 32'(busy), 1);
        check("z_tick1", 32'(tick), 0);
        cmd_tc = 4'd2; cmd_rep = 8'd1;
        for (int k = 2; k <= 7; k++) begin
            cyc();
            check("z_tick", 32'(tick), 32'((k >= 2) && (k <= 5)));
            check("z_done", 32'(done), 32'(k == 5));
            if (k == 6) begin
                check("z_ready6", 32'(cmd_ready), 1);
                check("z_busy6",  32'(busy),      0);
            end
            if (k == 7) begin
                check("z2_busy",  32'(busy),      1);
                check("z2_ready", 32'(cmd_ready), 0);
                check("z2_cnt",   32'(cnt),       0);
            end
        end
        cmd_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (done) begin
                found = 1;
                break;
            end
        end
        check("z2_finished", found, 1);
        cyc();

        // Reset mid-job, then a fresh full-length job.
        accept_job(7, 3);
        wait_cnt(4, 12);
        rst_n = 1'b0;
        cyc();
        check("mr_cnt",   32'(cnt),       0);
        check("mr_busy",  32'(busy),      0);
        check("mr_ready", 32'(cmd_ready), 0);
        check("mr_done",  32'(done),      0);
        check("mr_tick",  32'(tick),      0);
        check("mr_rep",   32'(rep_cnt),   0);
        rst_n = 1'b1;
        cyc();
        check("mr_ready_after", 32'(cmd_ready), 1);
        accept_job(7, 1);
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) cyc();
            check("fr_cnt",  32'(cnt),  32'((k <= 8) ? k - 1 : 0));
            check("fr_tick", 32'(tick), 32'(k == 9));
            check("fr_done", 32'(done), 32'(k == 9));
        end

        // Random phase, checked every cycle against the model.
        repeat (3000) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_tc    = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 15))
                                                    : CW'($urandom_range(0, 3));
            cmd_rep   = RW'($urandom_range(0, 3));
            pause     = ($urandom_range(0, 6) == 0);
            abort     = ($urandom_range(0, 40) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
